// File: rtl/bus_rx_pkg.sv
// Shared definitions for the bus receiver: default geometry, counter width,
// the captured-word record and a saturating counter helper.
package bus_rx_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_NDRV  = 4;
  localparam int DEF_DEPTH = 4;
  localparam int CNT_W     = 8;

  // One captured bus word tagged with the index of the driver that sent it.
  typedef struct packed {
    logic [DEF_DW-1:0]           data;
    logic [$clog2(DEF_NDRV)-1:0] src;
  } rx_word_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/bus_rx_fifo.sv
// Synchronous FIFO for captured words. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate occupancy counter.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bus_rx_fifo
  import bus_rx_pkg::*;
#(
  parameter type T     = rx_word_t,
  parameter int  DEPTH = DEF_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];
  logic        full_s, empty_s, do_push_s, do_pop_s;

  // Derive full/empty from the pointers and decide which operations occur.
  always_comb begin
    full_s    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty_s   = (wr_ptr_q == rd_ptr_q);
    do_pop_s  = pop_i && !empty_s;
    do_push_s = push_i && (!full_s || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + {{AW{1'b0}}, 1'b1}) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + {{AW{1'b0}}, 1'b1}) : rd_ptr_q;
  end

  // Pointer and storage update; reset clears storage so the head reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_s;
  assign empty_o = empty_s;

endmodule

// File: rtl/bus_receiver.sv
// Receive side of the shared tri-state bus. On a sample strobe the enables
// are classified: exactly one active driver captures {bus, driver index}
// into the FIFO, none sets the floating flag, several set the contention
// flag and bump the contention counter. Strobes lost to a full FIFO are
// counted. Bus and enables are ignored outside strobe cycles.
module bus_receiver
  import bus_rx_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int NDRV  = DEF_NDRV,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SW    = $clog2(NDRV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    bus,
  input  logic [NDRV-1:0]  en_n,
  input  logic             sample,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [SW-1:0]    out_src,
  output logic             contention,
  output logic             floating,
  input  logic             clear_flags,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] cont_cnt
);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] src;
  } word_t;

  logic [NDRV-1:0]  en_s;
  logic             none_s, one_s, many_s;
  logic [SW-1:0]    idx_s;
  word_t            wr_word_s, head_s;
  logic             push_req_s, pop_s, drop_s;
  logic             fifo_full_s, fifo_empty_s;

  logic             contention_q, contention_d;
  logic             floating_q, floating_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] cont_cnt_q, cont_cnt_d;

  // Count active drivers (none / exactly one / several) and find the lowest active index.
  always_comb begin
    en_s   = ~en_n;
    none_s = (en_s == {NDRV{1'b0}});
    one_s  = !none_s && ((en_s & (en_s - {{(NDRV-1){1'b0}}, 1'b1})) == {NDRV{1'b0}});
    many_s = !none_s && !one_s;
    idx_s  = {SW{1'b0}};
    for (int i = NDRV - 1; i >= 0; i--) begin
      idx_s = en_s[i] ? SW'(i) : idx_s;
    end
    wr_word_s.data = bus;
    wr_word_s.src  = idx_s;
  end

  // Handshake: pop only a valid head; a capture that finds no room is a drop.
  always_comb begin
    pop_s      = !fifo_empty_s && out_ready;
    push_req_s = sample && one_s;
    drop_s     = push_req_s && fifo_full_s && !pop_s;
  end

  // Sticky flags (a new event beats clear) and saturating event counters.
  always_comb begin
    contention_d = (contention_q && !clear_flags) || (sample && many_s);
    floating_d   = (floating_q && !clear_flags) || (sample && none_s);
    cont_cnt_d   = (sample && many_s) ? sat_inc(cont_cnt_q) : cont_cnt_q;
    drop_cnt_d   = drop_s ? sat_inc(drop_cnt_q) : drop_cnt_q;
  end

  // Flag and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      contention_q <= 1'b0;
      floating_q   <= 1'b0;
      cont_cnt_q   <= {CNT_W{1'b0}};
      drop_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      contention_q <= contention_d;
      floating_q   <= floating_d;
      cont_cnt_q   <= cont_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  bus_rx_fifo #(
    .T     (word_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req_s),
    .wdata_i (wr_word_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign out_valid  = !fifo_empty_s;
  assign out_data   = head_s.data;
  assign out_src    = head_s.src;
  assign contention = contention_q;
  assign floating   = floating_q;
  assign drop_cnt   = drop_cnt_q;
  assign cont_cnt   = cont_cnt_q;

endmodule

// File: tb/tb_bus_receiver.sv
// Directed bench for bus_receiver: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_bus_receiver;

  localparam int DW    = 8;
  localparam int NDRV  = 4;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   bus;
  logic [NDRV-1:0] en_n;
  logic            sample;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            contention;
  logic            floating;
  logic            clear_flags;
  logic [7:0]      drop_cnt;
  logic [7:0]      cont_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bus_receiver #(.DW(DW), .NDRV(NDRV), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .en_n        (en_n),
    .sample      (sample),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_src     (out_src),
    .contention  (contention),
    .floating    (floating),
    .clear_flags (clear_flags),
    .drop_cnt    (drop_cnt),
    .cont_cnt    (cont_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_data[$];
  int m_src[$];
  bit m_cont  = 1'b0;
  bit m_float = 1'b0;
  int m_drop  = 0;
  int m_ccnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Model update from the rules: classify by count of active drivers, queue semantics.
  always @(posedge clk) begin
    int  n;
    int  src;
    bit  do_pop;
    bit  do_push;
    if (rst) begin
      m_data.delete();
      m_src.delete();
      m_cont  = 1'b0;
      m_float = 1'b0;
      m_drop  = 0;
      m_ccnt  = 0;
    end else begin
      do_pop  = (m_data.size() != 0) && out_ready;
      do_push = 1'b0;
      if (clear_flags) begin
        m_cont  = 1'b0;
        m_float = 1'b0;
      end
      if (sample) begin
        n = $countones(~en_n);
        if (n == 0) begin
          m_float = 1'b1;
        end else if (n >= 2) begin
          m_cont = 1'b1;
          if (m_ccnt < 255) m_ccnt++;
        end else begin
          src = 0;
          for (int i = 0; i < NDRV; i++) if (!en_n[i]) src = i;
          if (m_data.size() < DEPTH || do_pop) do_push = 1'b1;
          else if (m_drop < 255) m_drop++;
        end
      end
      if (do_pop) begin
        void'(m_data.pop_front());
        void'(m_src.pop_front());
      end
      if (do_push) begin
        m_data.push_back(int'(bus));
        m_src.push_back(src);
      end
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", int'(out_valid), int'(m_data.size() != 0));
      if (m_data.size() != 0) begin
        chk("m_data", int'(out_data), m_data[0]);
        chk("m_src", int'(out_src), m_src[0]);
      end
      chk("m_contention", int'(contention), int'(m_cont));
      chk("m_floating", int'(floating), int'(m_float));
      chk("m_drop_cnt", int'(drop_cnt), m_drop);
      chk("m_cont_cnt", int'(cont_cnt), m_ccnt);
    end
  end

  // One clock: inputs captured at posedge, outputs observed at following negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input logic [3:0] e, input logic [7:0] d);
    en_n   = e;
    bus    = d;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    en_n   = 4'b1111;
    bus    = 8'hxx;
  endtask

  initial begin
    rst = 1'b1; bus = 8'h00; en_n = 4'b1111; sample = 1'b0;
    out_ready = 1'b0; clear_flags = 1'b0;
    tick();
    tick();
    // Reset values
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_src", int'(out_src), 0);
    chk("rst_cont", int'(contention), 0);
    chk("rst_float", int'(floating), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_ccnt", int'(cont_cnt), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();

    // Single-driver capture
    strobe(4'b1101, 8'hA5);
    chk("cap_valid", int'(out_valid), 1);
    chk("cap_data", int'(out_data), 8'hA5);
    chk("cap_src", int'(out_src), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("cap_popped", int'(out_valid), 0);

    // Contention, then clear alone
    strobe(4'b1100, 8'h11);
    chk("cont_flag", int'(contention), 1);
    chk("cont_cnt1", int'(cont_cnt), 1);
    chk("cont_novalid", int'(out_valid), 0);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("cont_cleared", int'(contention), 0);
    chk("cont_cnt_kept", int'(cont_cnt), 1);

    // Floating, then clear together with a new floating strobe
    strobe(4'b1111, 8'h22);
    chk("float_flag", int'(floating), 1);
    clear_flags = 1'b1;
    strobe(4'b1111, 8'h23);
    clear_flags = 1'b0;
    chk("float_set_wins", int'(floating), 1);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    chk("float_cleared", int'(floating), 0);

    // Overflow: 5 strobes into depth 4
    for (int d = 1; d <= 5; d++) strobe(4'b1110, d[7:0]);
    chk("ovf_drop", int'(drop_cnt), 1);
    chk("ovf_head", int'(out_data), 1);
    out_ready = 1'b1;
    strobe(4'b1110, 8'd6);
    out_ready = 1'b0;
    chk("ovf_drop_kept", int'(drop_cnt), 1);
    chk("ovf_head2", int'(out_data), 2);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_drained", int'(out_valid), 0);
    chk("ovf_cnt_after_clear", int'(cont_cnt), 1);

    // Backpressure and ordering with mixed sources
    strobe(4'b0111, 8'h10);
    strobe(4'b1011, 8'h11);
    strobe(4'b1101, 8'h12);
    strobe(4'b1110, 8'h13);
    chk("bp_head", int'(out_data), 8'h10);
    chk("bp_src", int'(out_src), 3);
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 1);
      tick();
    end
    out_ready = 1'b0;
    chk("bp_drained", int'(out_valid), 0);

    // Push and pop request while empty: no bypass
    out_ready = 1'b1;
    strobe(4'b1011, 8'h77);
    chk("nobyp_valid", int'(out_valid), 1);
    chk("nobyp_data", int'(out_data), 8'h77);
    chk("nobyp_src", int'(out_src), 2);
    tick();
    out_ready = 1'b0;
    chk("nobyp_popped", int'(out_valid), 0);

    // Reset mid-stream after counter saturation
    strobe(4'b1110, 8'h31);
    strobe(4'b1101, 8'h32);
    strobe(4'b1011, 8'h33);
    for (int i = 0; i < 300; i++) strobe(4'b0000, 8'h44);
    chk("sat_ccnt", int'(cont_cnt), 255);
    chk("sat_cont", int'(contention), 1);
    chk("sat_valid", int'(out_valid), 1);
    rst = 1'b1;
    strobe(4'b1110, 8'h55);
    rst = 1'b0;
    chk("mrst_valid", int'(out_valid), 0);
    chk("mrst_data", int'(out_data), 0);
    chk("mrst_src", int'(out_src), 0);
    chk("mrst_cont", int'(contention), 0);
    chk("mrst_float", int'(floating), 0);
    chk("mrst_drop", int'(drop_cnt), 0);
    chk("mrst_ccnt", int'(cont_cnt), 0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
